// File: rtl/brisc_pkg.sv
// brisc shared definitions: opcodes, stage
// encoding, trap causes and opcode classes.
package brisc_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd5
  } stage_e;

  typedef enum logic [1:0] {
    TRAP_NONE    = 2'd0,
    TRAP_ILLEGAL = 2'd1,
    TRAP_BUS     = 2'd2
  } trap_e;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_SYSTEM,
    CLS_ILLEGAL
  } op_class_e;

endpackage

// File: rtl/brisc_stage_ctrl_if.sv
// brisc memory handshake bundle: instruction
// and data req/ack plus the store strobe.
interface brisc_stage_ctrl_if;

  logic imem_req;
  logic imem_ack;
  logic dmem_req;
  logic dmem_ack;
  logic mem_w_en;

  modport master (
    output imem_req,
    output dmem_req,
    output mem_w_en,
    input  imem_ack,
    input  dmem_ack
  );

  modport slave (
    input  imem_req,
    input  dmem_req,
    input  mem_w_en,
    output imem_ack,
    output dmem_ack
  );

endinterface

// File: rtl/brisc_op_class.sv
// brisc opcode-to-class decoder, purely
// combinational; shared with decode logic.
module brisc_op_class
  import brisc_pkg::*;
(
  input  logic [6:0] op,
  output op_class_e  cls
);

  // map the 7-bit major opcode to its class
  always_comb begin
    cls = CLS_ILLEGAL;
    case (op)
      OP_LOAD:   cls = CLS_LOAD;
      OP_STORE:  cls = CLS_STORE;
      OP_BRANCH: cls = CLS_BRANCH;
      OP_JAL,
      OP_JALR:   cls = CLS_JUMP;
      OP_OP,
      OP_IMM,
      OP_LUI,
      OP_AUIPC:  cls = CLS_ALU;
      OP_SYSTEM: cls = CLS_SYSTEM;
      default:   cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/brisc_stage_ctrl.sv
// brisc multicycle sequencer: IF/ID/EX/MEM/WB
// stepping, memory handshakes, traps, counters.
module brisc_stage_ctrl
  import brisc_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       ir_op,
  input  logic             halt_req,
  brisc_stage_ctrl_if.master bus,
  output logic [2:0]       stage,
  output logic             ir_en,
  output logic             ab_en,
  output logic             alu_en,
  output logic             lmd_en,
  output logic             pc_en,
  output logic             reg_w_en,
  output logic             halted,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  localparam int TW =
    (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX =
    TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  stage_e     state_q, state_d;
  trap_e      cause_q, cause_d;
  logic       pend_q, pend_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] ret_q, ret_d;

  op_class_e cls;
  logic      waiting;
  logic      tmo;
  logic      is_mem;

  brisc_op_class u_cls (
    .op  (ir_op),
    .cls (cls)
  );

  assign is_mem = (cls == CLS_LOAD) ||
                  (cls == CLS_STORE);

  assign waiting =
    ((state_q == ST_IF)  && !bus.imem_ack) ||
    ((state_q == ST_MEM) && !bus.dmem_ack);

  assign tmo = (TIMEOUT > 0) && waiting &&
               (timer_q == TMAX);

  // next state, trap cause, held halt, timer, counters
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    pend_d  = pend_q | halt_req;
    timer_d = timer_q;
    cyc_d   = cyc_q;
    ret_d   = ret_q;
    case (state_q)
      ST_IF: begin
        if (bus.imem_ack) begin
          state_d = ST_ID;
        end else if (tmo) begin
          state_d = ST_HALT;
          cause_d = TRAP_BUS;
        end
      end
      ST_ID: begin
        unique case (1'b1)
          (cls == CLS_SYSTEM): begin
            state_d = ST_HALT;
            cause_d = TRAP_NONE;
          end
          (cls == CLS_ILLEGAL): begin
            state_d = ST_HALT;
            cause_d = TRAP_ILLEGAL;
          end
          default: state_d = ST_EX;
        endcase
      end
      ST_EX: begin
        state_d = is_mem ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        if (bus.dmem_ack) begin
          state_d = ST_WB;
        end else if (tmo) begin
          state_d = ST_HALT;
          cause_d = TRAP_BUS;
        end
      end
      ST_WB: begin
        pend_d = 1'b0;
        if (halt_req || pend_q) begin
          state_d = ST_HALT;
          cause_d = TRAP_NONE;
        end else begin
          state_d = ST_IF;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IF;
    endcase
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (waiting) begin
      timer_d = timer_q + TW'(1);
    end
    if (state_q != ST_HALT) begin
      cyc_d = cyc_q + CNT_W'(1);
    end
    if (state_q == ST_WB) begin
      ret_d = ret_q + CNT_W'(1);
    end
  end

  // state and counter registers, sync reset wins
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IF;
      cause_q <= TRAP_NONE;
      pend_q  <= 1'b0;
      timer_q <= '0;
      cyc_q   <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      pend_q  <= pend_d;
      timer_q <= timer_d;
      cyc_q   <= cyc_d;
      ret_q   <= ret_d;
    end
  end

  assign bus.imem_req = (state_q == ST_IF);
  assign bus.dmem_req = (state_q == ST_MEM);
  assign bus.mem_w_en = (state_q == ST_MEM) &&
                        (cls == CLS_STORE);

  assign ir_en  = (state_q == ST_IF) &&
                  bus.imem_ack;
  assign ab_en  = (state_q == ST_ID);
  assign alu_en = (state_q == ST_EX);
  assign lmd_en = (state_q == ST_MEM) &&
                  bus.dmem_ack &&
                  (cls == CLS_LOAD);
  assign pc_en  = (state_q == ST_WB);
  assign reg_w_en = (state_q == ST_WB) &&
                    (cls != CLS_STORE) &&
                    (cls != CLS_BRANCH);

  assign halted      = (state_q == ST_HALT);
  assign stage       = state_q;
  assign trap_cause  = cause_q;
  assign cycle_cnt   = cyc_q;
  assign instret_cnt = ret_q;

endmodule
